pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - per-frame Pong game sequencer: paddles, ball, scores, game FSM
module pong_game_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_L_X   = 16,
    parameter int PADDLE_R_X   = 616,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_DELAY  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_up_l,
    input  logic       btn_dn_l,
    input  logic       btn_up_r,
    input  logic       btn_dn_r,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] state,
    output logic       game_over
);
    localparam int CW = $clog2(SERVE_DELAY);

    localparam logic [10:0] BALL_X0 = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y0 = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] PAD_Y0  = 11'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [10:0] PAD_MAX = 11'(V_ACTIVE - PADDLE_H);
    localparam logic [10:0] BY_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] BX_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] LF      = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] RF      = 11'(PADDLE_R_X - BALL_SIZE);
    localparam logic [10:0] P_SPD   = 11'(PADDLE_SPEED);
    localparam logic [10:0] B_SPD   = 11'(BALL_SPEED);
    localparam logic [10:0] B_SZ    = 11'(BALL_SIZE);
    localparam logic [10:0] P_H     = 11'(PADDLE_H);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

    state_t        state_q, state_d;
    logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]    pad_l_q, pad_l_d, pad_r_q, pad_r_d;
    logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          over_q;

    logic [10:0] bx, by, pl, pr, nbx, nby;
    logic        ndx, ndy, ov_l, ov_r, miss_l, miss_r;
    logic [3:0]  sl_inc, sr_inc;

    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
        logic [10:0] y11;
        y11 = {1'b0, y};
        if (up && !dn)
            y11 = (y11 <= P_SPD) ? 11'd0 : y11 - P_SPD;
        else if (dn && !up)
            y11 = (y11 + P_SPD >= PAD_MAX) ? PAD_MAX : y11 + P_SPD;
        return y11[9:0];
    endfunction

    assign bx     = {1'b0, ball_x_q};
    assign by     = {1'b0, ball_y_q};
    assign pl     = {1'b0, pad_l_q};
    assign pr     = {1'b0, pad_r_q};
    assign ov_l   = (by + B_SZ > pl) && (by < pl + P_H);
    assign ov_r   = (by + B_SZ > pr) && (by < pr + P_H);
    assign sl_inc = (score_l_q == 4'd15) ? score_l_q : score_l_q + 4'd1;
    assign sr_inc = (score_r_q == 4'd15) ? score_r_q : score_r_q + 4'd1;

    // Candidate ball motion for a PLAY tick, always from pre-update positions.
    always_comb begin
        nby    = by;
        ndy    = dir_y_q;
        nbx    = bx;
        ndx    = dir_x_q;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (dir_y_q) begin
            if (by + B_SPD >= BY_MAX) begin
                nby = BY_MAX;
                ndy = 1'b0;
            end else begin
                nby = by + B_SPD;
            end
        end else if (by <= B_SPD) begin
            nby = 11'd0;
            ndy = 1'b1;
        end else begin
            nby = by - B_SPD;
        end
        if (!dir_x_q) begin
            if (bx >= LF && bx - B_SPD <= LF && ov_l) begin
                nbx = LF;
                ndx = 1'b1;
            end else if (bx <= B_SPD) begin
                nbx    = 11'd0;
                miss_l = 1'b1;
            end else begin
                nbx = bx - B_SPD;
            end
        end else begin
            if (bx <= RF && bx + B_SPD >= RF && ov_r) begin
                nbx = RF;
                ndx = 1'b0;
            end else if (bx + B_SPD >= BX_MAX) begin
                nbx    = BX_MAX;
                miss_r = 1'b1;
            end else begin
                nbx = bx + B_SPD;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        pad_l_d   = pad_l_q;
        pad_r_d   = pad_r_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SERVE;
                    cnt_d   = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    pad_l_d = paddle_next(pad_l_q, btn_up_l, btn_dn_l);
                    pad_r_d = paddle_next(pad_r_q, btn_up_r, btn_dn_r);
                    if (cnt_q == CNT_LAST) state_d = S_PLAY;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    pad_l_d  = paddle_next(pad_l_q, btn_up_l, btn_dn_l);
                    pad_r_d  = paddle_next(pad_r_q, btn_up_r, btn_dn_r);
                    ball_x_d = nbx[9:0];
                    ball_y_d = nby[9:0];
                    dir_x_d  = ndx;
                    dir_y_d  = ndy;
                    if (miss_l || miss_r) begin
                        if (miss_l) score_r_d = sr_inc;
                        else        score_l_d = sl_inc;
                        if ((miss_l && sr_inc == WIN) || (miss_r && sl_inc == WIN)) begin
                            state_d = S_OVER;
                        end else begin
                            // Serve heads toward whoever conceded the point.
                            state_d  = S_SERVE;
                            cnt_d    = '0;
                            ball_x_d = BALL_X0[9:0];
                            ball_y_d = BALL_Y0[9:0];
                            dir_x_d  = miss_r;
                            dir_y_d  = 1'b1;
                        end
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d   = S_SERVE;
                    cnt_d     = '0;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    ball_x_d  = BALL_X0[9:0];
                    ball_y_d  = BALL_Y0[9:0];
                    pad_l_d   = PAD_Y0[9:0];
                    pad_r_d   = PAD_Y0[9:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ball_x_q  <= BALL_X0[9:0];
            ball_y_q  <= BALL_Y0[9:0];
            pad_l_q   <= PAD_Y0[9:0];
            pad_r_q   <= PAD_Y0[9:0];
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= '0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            pad_l_q   <= pad_l_d;
            pad_r_q   <= pad_r_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cnt_q     <= cnt_d;
            over_q    <= (state_d == S_OVER);
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign paddle_l_y = pad_l_q;
    assign paddle_r_y = pad_r_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign state      = state_q;
    assign game_over  = over_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl against a per-frame game model
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, frame_tick, start;
    logic       btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
    logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [3:0] score_l, score_r;
    logic [1:0] state;
    logic       game_over;

    localparam logic [63:0] RESET_VEC = {13'd0, 10'd316, 10'd236, 10'd208, 10'd208, 4'd0, 4'd0, 2'd0, 1'b0};

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_dx, m_dy, m_cnt;

    pong_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .btn_up_l(btn_up_l), .btn_dn_l(btn_dn_l), .btn_up_r(btn_up_r), .btn_dn_r(btn_dn_r),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .score_l(score_l), .score_r(score_r), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] dut_vec();
        return {13'd0, ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r, state, game_over};
    endfunction

    function automatic logic [63:0] model_vec();
        return {13'd0, 10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr), 4'(m_sl), 4'(m_sr), 2'(m_st), 1'(m_st == 3)};
    endfunction

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
        m_sl = 0; m_sr = 0; m_st = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
    endtask

    function automatic int pad(input int p, input bit u, input bit d);
        if (u && !d) return (p - 4 < 0) ? 0 : p - 4;
        if (d && !u) return (p + 4 > 416) ? 416 : p + 4;
        return p;
    endfunction

    task automatic model_step(input bit tk, input bit st, input bit ul, input bit dl, input bit ur, input bit dr);
        int bx, by, dx, dy;
        bit ml, mr;
        ml = 0; mr = 0;
        case (m_st)
            0: if (st) begin m_st = 1; m_cnt = 0; end
            1: if (tk) begin
                m_pl = pad(m_pl, ul, dl);
                m_pr = pad(m_pr, ur, dr);
                if (m_cnt == 59) m_st = 2; else m_cnt++;
            end
            2: if (tk) begin
                dy = m_dy;
                if (m_dy == 1) begin
                    if (m_by + 2 >= 472) begin by = 472; dy = 0; end else by = m_by + 2;
                end else begin
                    if (m_by <= 2) begin by = 0; dy = 1; end else by = m_by - 2;
                end
                dx = m_dx;
                if (m_dx == 0) begin
                    if (m_bx >= 24 && m_bx - 2 <= 24 && m_by + 8 > m_pl && m_by < m_pl + 64) begin bx = 24; dx = 1; end
                    else if (m_bx <= 2) begin bx = 0; ml = 1; end
                    else bx = m_bx - 2;
                end else begin
                    if (m_bx <= 608 && m_bx + 2 >= 608 && m_by + 8 > m_pr && m_by < m_pr + 64) begin bx = 608; dx = 0; end
                    else if (m_bx + 2 >= 632) begin bx = 632; mr = 1; end
                    else bx = m_bx + 2;
                end
                m_pl = pad(m_pl, ul, dl);
                m_pr = pad(m_pr, ur, dr);
                m_bx = bx; m_by = by; m_dx = dx; m_dy = dy;
                if (ml) m_sr = (m_sr == 15) ? 15 : m_sr + 1;
                if (mr) m_sl = (m_sl == 15) ? 15 : m_sl + 1;
                if ((ml && m_sr == 9) || (mr && m_sl == 9)) m_st = 3;
                else if (ml || mr) begin
                    m_st = 1; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = mr ? 1 : 0; m_dy = 1;
                end
            end
            default: if (st) begin
                m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208; m_st = 1; m_cnt = 0;
            end
        endcase
    endtask

    task automatic cycle(input bit tk, input bit st, input bit ul, input bit dl, input bit ur, input bit dr);
        frame_tick = tk; start = st;
        btn_up_l = ul; btn_dn_l = dl; btn_up_r = ur; btn_dn_r = dr;
        model_step(tk, st, ul, dl, ur, dr);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        check_eq("cyc", dut_vec(), exp_q.pop_front());
    endtask

    function automatic logic [1:0] steer(input logic [9:0] py, input logic [9:0] by, input bit av);
        int pc, bc;
        pc = int'(py) + 32;
        bc = int'(by) + 4;
        if ($urandom_range(0, 15) == 0) return 2'b11;
        if (av) return (bc >= pc) ? 2'b10 : 2'b01;
        if (pc > bc + 2) return 2'b10;
        if (pc + 2 < bc) return 2'b01;
        return 2'b00;
    endfunction

    // Tick/idle cycle pairs; target < 0 runs for exactly limit ticks.
    task automatic run(input bit av_l, input bit av_r, input int target, input int limit, input string tag);
        logic [1:0] bl, br;
        logic [3:0] rb;
        bit st;
        int n;
        n = 0;
        while (n < limit && !(target >= 0 && int'(state) == target)) begin
            bl = steer(paddle_l_y, ball_y, av_l);
            br = steer(paddle_r_y, ball_y, av_r);
            st = (m_st == 1 || m_st == 2) && ($urandom_range(0, 7) == 0);
            cycle(1'b1, st, bl[1], bl[0], br[1], br[0]);
            rb = 4'($urandom());
            cycle(1'b0, 1'b0, rb[3], rb[2], rb[1], rb[0]);
            n++;
        end
        if (target >= 0) check_eq(tag, 64'(state), 64'(target));
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_up_r = 1'b0; btn_dn_r = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_vec", dut_vec(), RESET_VEC);
        rst_n = 1'b1;
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("idle_hold", dut_vec(), RESET_VEC);

        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("serve_entry", 64'(state), 64'd1);
        for (int i = 0; i < 59; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        check_eq("serve_59", 64'(state), 64'd1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("play_at_60", 64'(state), 64'd2);
        check_eq("clamp_top", 64'(paddle_l_y), 64'd0);
        check_eq("both_hold", 64'(paddle_r_y), 64'd208);

        run(1'b0, 1'b0, -1, 900, "rally");
        check_eq("rally_alive", 64'(state), 64'd2);
        check_eq("rally_scores", 64'({score_l, score_r}), 64'd0);

        run(1'b1, 1'b0, 1, 700, "miss_l");
        check_eq("score_r", 64'(score_r), 64'd1);
        check_eq("recentre", 64'({ball_x, ball_y}), 64'({10'd316, 10'd236}));
        run(1'b0, 1'b0, 2, 80, "reserve");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("serve_left", 64'(ball_x), 64'd314);

        run(1'b0, 1'b1, 3, 4000, "win_l");
        check_eq("score_l_win", 64'(score_l), 64'd9);
        check_eq("game_over", 64'(game_over), 64'd1);
        repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("over_hold", 64'(state), 64'd3);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("restart", dut_vec(), {13'd0, 10'd316, 10'd236, 10'd208, 10'd208, 4'd0, 4'd0, 2'd1, 1'b0});
        run(1'b0, 1'b0, 2, 100, "replay");
        run(1'b0, 1'b0, -1, 37, "midplay");

        #3 rst_n = 1'b0;
        #1;
        check_eq("async_reset", dut_vec(), RESET_VEC);
        model_reset();
        #3 rst_n = 1'b1;
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("post_reset", dut_vec(), RESET_VEC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
